fetch_unit: RTL and testbench

Parametrised instruction-fetch stage, the successor to the single-register fetch stage.
- Holds a writable instruction memory and a wrapping program counter.
- Fetches one instruction per cycle into a small fetch queue.
- Presents {pc, instruction} to decode over a valid/ready handshake.
- Adds jump redirect with queue flush, backpressure, asynchronous reset and a memory load port.

---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with a writable instruction memory, a
// wrapping program counter and a small FIFO fetch queue feeding decode.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   jump, jump_pc   redirect: flush the queue and load the PC with jump_pc
//   out_ready       decode accepts the head entry this cycle
//   out_valid       head entry valid
//   ins_out, pc_out head {instruction, pc}; both forced to 0 when not valid
//   occupancy       entries currently held in the queue (0..BUF_DEPTH)
//   imem_we/waddr/wdata  instruction memory load port
module fetch_unit #(
  parameter int unsigned   INS_W     = 32,
  parameter int unsigned   PC_W      = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned   BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           jump,
  input  logic [PC_W-1:0]                jump_pc,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [INS_W-1:0]               ins_out,
  output logic [PC_W-1:0]                pc_out,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy,
  input  logic                           imem_we,
  input  logic [PC_W-1:0]                imem_waddr,
  input  logic [INS_W-1:0]               imem_wdata
);

  localparam int unsigned MEM_D = 1 << PC_W;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);

  logic [INS_W-1:0] r_mem   [MEM_D];
  logic [INS_W-1:0] r_q_ins [BUF_DEPTH];
  logic [PC_W-1:0]  r_q_pc  [BUF_DEPTH];

  logic [PC_W-1:0]  r_pc;
  logic [PTR_W-1:0] r_rd, r_wr;
  logic [CNT_W-1:0] r_count;

  logic             w_pop, w_push;
  logic [INS_W-1:0] w_fetch;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Combinational read of the word at the current PC; since the write below
  // lands on the edge, a same-edge write to this address is not seen here.
  assign w_fetch = r_mem[r_pc];

  assign out_valid = (r_count != '0);
  assign ins_out   = out_valid ? r_q_ins[r_rd] : '0;
  assign pc_out    = out_valid ? r_q_pc[r_rd]  : '0;
  assign occupancy = r_count;

  assign w_pop  = out_valid & out_ready;
  // A pop on the same edge frees a slot, so a full queue still accepts a push.
  assign w_push = !jump & ((r_count < DEPTH_C) | w_pop);

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) r_mem[imem_waddr] <= imem_wdata;
  end

  // Queue payload needs no reset: it is only visible through out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_ins[r_wr] <= w_fetch;
      r_q_pc[r_wr]  <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (jump) begin
      // Redirect wins: drop everything, including a pop offered this cycle.
      r_pc    <= jump_pc;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc <= r_pc + 1'b1;  // wraps modulo 2**PC_W
        r_wr <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int INS_W = 32;
  localparam int PC_W  = 5;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             jump = 1'b0;
  logic [PC_W-1:0]  jump_pc = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [INS_W-1:0] ins_out;
  logic [PC_W-1:0]  pc_out;
  logic [CW-1:0]    occupancy;
  logic             imem_we = 1'b0;
  logic [PC_W-1:0]  imem_waddr = '0;
  logic [INS_W-1:0] imem_wdata = '0;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_unit #(.INS_W(INS_W), .PC_W(PC_W), .RESET_PC('0), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .jump(jump), .jump_pc(jump_pc), .out_ready(out_ready),
    .out_valid(out_valid), .ins_out(ins_out), .pc_out(pc_out), .occupancy(occupancy),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=0x%0h exp=0x%0h", tag, act, exp);
  endtask

  // Advance one edge; inputs changed and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input int pc, input logic [31:0] ins);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".pc"},    64'(pc_out),    64'(pc));
    chk({tag, ".ins"},   64'(ins_out),   64'(ins));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".pc"},    64'(pc_out),    64'd0);
    chk({tag, ".ins"},   64'(ins_out),   64'd0);
    chk({tag, ".occ"},   64'(occupancy), 64'd0);
  endtask

  initial begin
    // Preload mem[k] = k + 0x100 while held in reset.
    #1;
    for (int k = 0; k < 32; k++) begin
      imem_we = 1'b1; imem_waddr = PC_W'(k); imem_wdata = 32'(k + 'h100);
      step();
    end
    imem_we = 1'b0;
    chk_empty("reset");

    // 1/2: stream from reset with out_ready high, through the PC wrap.
    out_ready = 1'b1;
    rst = 1'b0;
    chk("rel.valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 34; k++) begin
      step();
      chk_head($sformatf("stream%0d", k), k % 32, 32'((k % 32) + 'h100));
      chk($sformatf("stream%0d.occ", k), 64'(occupancy), 64'd1);
    end

    // 3: backpressure from reset.
    rst = 1'b1; step(); rst = 1'b0; out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("bp%0d.occ", i), 64'(occupancy), 64'((i < 2) ? i : 2));
      chk_head($sformatf("bp%0d", i), 0, 32'h100);
    end
    out_ready = 1'b1;
    chk_head("bp_rel0", 0, 32'h100);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk_head($sformatf("bp_rel%0d", j), j, 32'(j + 'h100));
      chk($sformatf("bp_rel%0d.occ", j), 64'(occupancy), 64'd2);
    end

    // 4: jump with a full queue and out_ready high.
    jump = 1'b1; jump_pc = 5'd22;
    step();
    jump = 1'b0;
    chk_empty("jmp_flush");
    step(); chk_head("jmp22", 22, 32'h116);
    step(); chk_head("jmp23", 23, 32'h117);
    step(); chk_head("jmp24", 24, 32'h118);

    // 5: async reset between edges clears outputs before the next edge.
    #3;
    rst = 1'b1;
    #1;
    chk_empty("async_rst");
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_head($sformatf("restart%0d", k), k, 32'(k + 'h100));
    end

    // 6: write mem[5] on the edge that fetches PC 5 -> old word is queued.
    imem_we = 1'b1; imem_waddr = 5'd5; imem_wdata = 32'hDEADBEEF;
    step();
    imem_we = 1'b0;
    chk_head("coll_old", 5, 32'h105);
    jump = 1'b1; jump_pc = 5'd5;
    step();
    jump = 1'b0;
    chk_empty("coll_flush");
    step(); chk_head("coll_new", 5, 32'hDEADBEEF);
    step(); chk_head("coll_next", 6, 32'h106);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
